// File: rtl/rgmii_pkg.sv
// Shared constants and FSM state type for the RGMII header sniffer.
package rgmii_pkg;
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;
  localparam int         HDR_BYTES    = 14;

  typedef enum logic [1:0] {HUNT, PREAMBLE, HEADER, DRAIN} rx_state_t;
endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first; ready also rises in the last clk of the
// stop bit so a waiting byte follows with no idle gap.
module uart_tx_8n1 #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       SW0,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    sh;
  logic          bit_end;

  assign bit_end = (cnt == CW'(CPB - 1));
  assign ready   = !busy || (bit_end && bit_idx == 4'd9);

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '1;
    end else if (valid && ready) begin
      busy    <= 1'b1;
      tx      <= 1'b0;
      sh      <= {1'b1, data};
      cnt     <= '0;
      bit_idx <= '0;
    end else if (busy) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy <= 1'b0;
        end else begin
          // sh shifts out data bits, then the stop bit, then idle ones
          tx      <= sh[0];
          sh      <= {1'b1, sh[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/rgmii_header_sniffer.sv
// RGMII receive sniffer: hunts preamble/SFD, latches the 14-byte Ethernet
// header, reports status on LED and dumps the header over UART.
module rgmii_header_sniffer
  import rgmii_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int HDR_BYTES = 14
) (
  input  logic       clk,
  input  logic       SW0,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] LED,
  input  logic       rgm0_en,
  input  logic       rgm0_clk,
  input  logic [3:0] rgm0_d
);
  localparam int            BW   = $clog2(HDR_BYTES);
  localparam logic [BW-1:0] LAST = BW'(HDR_BYTES - 1);

  logic unused_rx;
  assign unused_rx = uart_rx;

  // Input synchronizers; en/d get one extra stage to stay aligned with nib_stb
  logic [1:0]      clk_sy, en_sy;
  logic [1:0][3:0] d_sy;
  logic            clk_q, en_q, nib_stb;
  logic [3:0]      d_q;

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      clk_sy  <= '0;
      en_sy   <= '0;
      d_sy    <= '0;
      clk_q   <= 1'b0;
      en_q    <= 1'b0;
      d_q     <= '0;
      nib_stb <= 1'b0;
    end else begin
      clk_sy  <= {clk_sy[0], rgm0_clk};
      en_sy   <= {en_sy[0], rgm0_en};
      d_sy    <= {d_sy[0], rgm0_d};
      clk_q   <= clk_sy[1];
      en_q    <= en_sy[1];
      d_q     <= d_sy[1];
      nib_stb <= clk_sy[1] & ~clk_q;
    end
  end

  rx_state_t                     state;
  logic [BW-1:0]                 byte_cnt, byte_idx;
  logic                          phase, hdr_valid, drop_flag, dump_busy;
  logic [3:0]                    low_nib;
  logic [HDR_BYTES-2:0][7:0]     hdr_buf;
  logic [HDR_BYTES-1:0][7:0]     hdr;
  logic [4:0]                    frame_cnt;
  logic                          tx_ready, uart_busy;

  assign uart_busy = hdr_valid | dump_busy | ~tx_ready;

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      state     <= HUNT;
      byte_cnt  <= '0;
      phase     <= 1'b0;
      low_nib   <= '0;
      hdr_buf   <= '0;
      hdr       <= '0;
      hdr_valid <= 1'b0;
      frame_cnt <= '0;
      drop_flag <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      case (state)
        HUNT:
          if (nib_stb && en_q && d_q == PREAMBLE_NIB) state <= PREAMBLE;
        PREAMBLE:
          if (!en_q) state <= HUNT;
          else if (nib_stb) begin
            if (d_q == SFD_NIB) begin
              // hdr is still being dumped: drop this frame rather than overwrite
              if (uart_busy) begin
                state     <= DRAIN;
                drop_flag <= 1'b1;
              end else begin
                state    <= HEADER;
                byte_cnt <= '0;
                phase    <= 1'b0;
              end
            end else if (d_q != PREAMBLE_NIB) begin
              state <= HUNT;
            end
          end
        HEADER:
          if (!en_q) state <= HUNT;
          else if (nib_stb) begin
            phase <= ~phase;
            if (!phase) begin
              low_nib <= d_q;
            end else if (byte_cnt == LAST) begin
              hdr       <= {d_q, low_nib, hdr_buf};
              hdr_valid <= 1'b1;
              frame_cnt <= frame_cnt + 5'd1;
              state     <= DRAIN;
            end else begin
              hdr_buf[byte_cnt] <= {d_q, low_nib};
              byte_cnt          <= byte_cnt + BW'(1);
            end
          end
        DRAIN:
          if (!en_q) state <= HUNT;
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      dump_busy <= 1'b0;
      byte_idx  <= '0;
    end else if (hdr_valid) begin
      dump_busy <= 1'b1;
      byte_idx  <= '0;
    end else if (dump_busy && tx_ready) begin
      byte_idx <= byte_idx + BW'(1);
      if (byte_idx == LAST) dump_busy <= 1'b0;
    end
  end

  uart_tx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tx (
    .clk   (clk),
    .SW0   (SW0),
    .data  (hdr[byte_idx]),
    .valid (dump_busy),
    .ready (tx_ready),
    .tx    (uart_tx)
  );

  assign LED = {frame_cnt, drop_flag, uart_busy, (state == PREAMBLE || state == HEADER)};
endmodule

// File: tb/tb_rgmii_header_sniffer.sv
// Directed bench for rgmii_header_sniffer: frames driven as nibble streams,
// UART output decoded into a byte queue and compared with known headers.
module tb_rgmii_header_sniffer;
  localparam int CLK_HZ = 50_000_000;
  localparam int CPB    = 16;
  localparam int BAUD   = CLK_HZ / CPB;
  localparam logic [111:0] FRAME_A = 112'h54ff01212324_123456789abc_0000;
  localparam logic [111:0] FRAME_B = 112'h010203040506_a0b1c2d3e4f5_0800;

  logic       clk = 1'b0, SW0 = 1'b1, uart_rx = 1'b1;
  logic       rgm0_en = 1'b0, rgm0_clk = 1'b0;
  logic [3:0] rgm0_d = 4'h0;
  logic       uart_tx;
  logic [7:0] LED;

  int n_checks = 0, n_fail = 0, frame_errs = 0;
  logic [7:0] rxq[$];

  rgmii_header_sniffer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .HDR_BYTES(14)) dut (
    .clk(clk), .SW0(SW0), .uart_rx(uart_rx), .uart_tx(uart_tx), .LED(LED),
    .rgm0_en(rgm0_en), .rgm0_clk(rgm0_clk), .rgm0_d(rgm0_d)
  );

  always #10 clk = ~clk;

  // UART decoder: samples mid-bit on the falling clk edge
  initial forever begin : dec
    logic [7:0] b;
    @(negedge uart_tx);
    repeat (CPB / 2) @(negedge clk);
    if (uart_tx !== 1'b0) frame_errs++;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    if (uart_tx !== 1'b1) frame_errs++;
    rxq.push_back(b);
  end

  task automatic nib(input logic [3:0] d, input logic en);
    rgm0_d = d; rgm0_en = en; rgm0_clk = 1'b0;
    #20 rgm0_clk = 1'b1;
    #20;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(4'h0, 1'b0);
  endtask

  task automatic send_frame(input logic [111:0] f, input int nb);
    logic [7:0] b;
    @(posedge clk); #3;
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b1);
    nib(4'hD, 1'b1);
    for (int i = 0; i < nb; i++) begin
      b = f[8*(13-i) +: 8];
      nib(b[3:0], 1'b1);
      nib(b[7:4], 1'b1);
    end
    idle(4);
  endtask

  task automatic wait_dump();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rxq.size() >= 14 && LED[1] == 1'b0) break;
    end
    n_checks++;
    if (i >= 4000) begin
      n_fail++; $display("FAIL dump_timeout got %0d bytes busy=%b exp 14 bytes busy=0", rxq.size(), LED[1]);
    end
  endtask

  task automatic check_dump(input logic [111:0] f, input string tag);
    logic [7:0] e;
    n_checks++;
    if (rxq.size() != 14) begin
      n_fail++; $display("FAIL %s_count got %0d exp 14", tag, rxq.size());
    end
    for (int i = 0; i < 14 && i < rxq.size(); i++) begin
      e = f[8*(13-i) +: 8];
      n_checks++;
      if (rxq[i] !== e) begin
        n_fail++; $display("FAIL %s_byte%0d got %h exp %h", tag, i, rxq[i], e);
      end
    end
    n_checks++;
    if (frame_errs != 0) begin
      n_fail++; $display("FAIL %s_framing got %0d errors exp 0", tag, frame_errs);
    end
    rxq.delete();
  endtask

  task automatic test_reset();
    #35;
    n_checks++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b exp 1", uart_tx); end
    n_checks++;
    if (LED !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h exp 00", LED); end
    @(posedge clk); #3 SW0 = 1'b0;
    repeat (200) @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx got %b exp 1", uart_tx); end
    n_checks++;
    if (LED !== 8'h00) begin n_fail++; $display("FAIL idle_led got %h exp 00", LED); end
  endtask

  task automatic test_abort();
    send_frame(FRAME_A, 6);
    repeat (300) @(negedge clk);
    n_checks++;
    if (rxq.size() != 0) begin n_fail++; $display("FAIL abort_uart got %0d bytes exp 0", rxq.size()); end
    n_checks++;
    if (LED !== 8'h00) begin n_fail++; $display("FAIL abort_led got %h exp 00", LED); end
  endtask

  task automatic test_good_frame();
    send_frame(FRAME_A, 14);
    n_checks++;
    if (LED[7:3] !== 5'd1) begin n_fail++; $display("FAIL good_cnt got %0d exp 1", LED[7:3]); end
    n_checks++;
    if (LED[1:0] !== 2'b10) begin n_fail++; $display("FAIL good_busy got %b exp 10", LED[1:0]); end
    wait_dump();
    check_dump(FRAME_A, "good");
    n_checks++;
    if (LED !== 8'h08) begin n_fail++; $display("FAIL good_after_led got %h exp 08", LED); end
  endtask

  task automatic test_bad_preamble();
    logic [7:0] b;
    @(posedge clk); #3;
    nib(4'h5, 1'b1); nib(4'h5, 1'b1); nib(4'h3, 1'b1); nib(4'hD, 1'b1);
    for (int i = 0; i < 14; i++) begin
      b = FRAME_A[8*(13-i) +: 8];
      nib(b[3:0], 1'b1);
      nib(b[7:4], 1'b1);
    end
    idle(4);
    repeat (300) @(negedge clk);
    n_checks++;
    if (rxq.size() != 0) begin n_fail++; $display("FAIL badpre_uart got %0d bytes exp 0", rxq.size()); end
    n_checks++;
    if (LED !== 8'h08) begin n_fail++; $display("FAIL badpre_led got %h exp 08", LED); end
  endtask

  task automatic test_busy_drop();
    send_frame(FRAME_B, 14);
    n_checks++;
    if (LED[7:1] !== 7'b00010_0_1) begin n_fail++; $display("FAIL busy_first got %b exp 0001001", LED[7:1]); end
    send_frame(FRAME_A, 14);
    n_checks++;
    if (LED[7:2] !== 6'b00010_1) begin n_fail++; $display("FAIL busy_drop got %b exp 000101", LED[7:2]); end
    wait_dump();
    repeat (400) @(negedge clk);
    check_dump(FRAME_B, "busy");
    n_checks++;
    if (LED !== 8'h14) begin n_fail++; $display("FAIL busy_after_led got %h exp 14", LED); end
  endtask

  task automatic test_async_reset();
    send_frame(FRAME_A, 14);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #5;
      if (uart_tx === 1'b0) break;
    end
    SW0 = 1'b1;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL areset_tx got %b exp 1", uart_tx); end
    n_checks++;
    if (LED !== 8'h00) begin n_fail++; $display("FAIL areset_led got %h exp 00", LED); end
    #100;
    @(posedge clk); #3 SW0 = 1'b0;
    repeat (400) @(negedge clk);
    n_checks++;
    if (LED !== 8'h00 || uart_tx !== 1'b1) begin
      n_fail++; $display("FAIL areset_after got led=%h tx=%b exp led=00 tx=1", LED, uart_tx);
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_good_frame();
    test_bad_preamble();
    test_busy_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
